// File: rtl/fp_divsqrt_allocator_pkg.sv
// Shared types and the flush-range test for the FP div/sqrt unit allocator.
package fp_divsqrt_allocator_pkg;

    localparam int ALLOC_NUM_UNITS = 2;
    localparam int ALLOC_TAG_W     = 7;
    localparam int ALLOC_UIDX_W    = (ALLOC_NUM_UNITS > 1) ? $clog2(ALLOC_NUM_UNITS) : 1;

    typedef logic [ALLOC_UIDX_W-1:0] fp_divsqrt_unit_index_path_t;

    typedef struct packed {
        logic                   owned;
        logic [ALLOC_TAG_W-1:0] tag;
    } fp_divsqrt_alloc_entry_t;

    // Circular active-list range [head, tail); head == tail is empty.
    function automatic logic in_flush_range(input logic [ALLOC_TAG_W-1:0] tag,
                                            input logic [ALLOC_TAG_W-1:0] head,
                                            input logic [ALLOC_TAG_W-1:0] tail);
        logic hit;
        hit = 1'b0;
        if (head < tail)
            hit = (tag >= head) && (tag < tail);
        else if (head > tail)
            hit = (tag >= head) || (tag < tail);
        return hit;
    endfunction

endpackage

// File: rtl/fp_divsqrt_rr_picker.sv
// Rotating-priority lane scan: gives each lane its scan position and its rank
// among the requesting lanes, starting at rr_ptr.
module fp_divsqrt_rr_picker
    import fp_divsqrt_allocator_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [PTR_W-1:0]               rr_ptr,
    input  logic [NUM_REQ-1:0]             req,
    output logic [NUM_REQ-1:0][PTR_W-1:0]  pos,
    output logic [NUM_REQ-1:0][PTR_W:0]    rank
);

    function automatic int scan_pos(input int lane, input logic [PTR_W-1:0] ptr);
        return (lane + NUM_REQ - int'(ptr)) % NUM_REQ;
    endfunction

    // NOTE: every output gets a default before the loops so no latch is inferred.
    always_comb begin
        pos  = '0;
        rank = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int cnt;
            cnt    = 0;
            pos[i] = PTR_W'(scan_pos(i, rr_ptr));
            for (int j = 0; j < NUM_REQ; j++) begin
                if (req[j] && (scan_pos(j, rr_ptr) < scan_pos(i, rr_ptr)))
                    cnt = cnt + 1;
            end
            rank[i] = (PTR_W + 1)'(cnt);
        end
    end

endmodule

// File: rtl/fp_divsqrt_allocator.sv
// Round-robin allocator of a pool of FP div/sqrt units to issue lanes.
// Optional FP_DIVSQRT_ALLOC_STATS_EN adds saturating grant/stall counters.
module fp_divsqrt_allocator
    import fp_divsqrt_allocator_pkg::*;
#(
    parameter  int NUM_REQ   = 2,
    parameter  int NUM_UNITS = ALLOC_NUM_UNITS,
    parameter  int TAG_W     = ALLOC_TAG_W,
    localparam int UIDX_W    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ*UIDX_W-1:0]  grant_unit,
    output logic [NUM_UNITS-1:0]       unit_acquire,
    output logic [NUM_UNITS*TAG_W-1:0] unit_tag,
    input  logic [NUM_UNITS-1:0]       unit_release,
    input  logic                       flush_valid,
    input  logic                       flush_all,
    input  logic [TAG_W-1:0]           flush_head,
    input  logic [TAG_W-1:0]           flush_tail,
    output logic [NUM_UNITS-1:0]       unit_owned,
    output logic [UIDX_W:0]            free_count
`ifdef FP_DIVSQRT_ALLOC_STATS_EN
   ,output logic [31:0]                stat_grants,
    output logic [31:0]                stat_stalls
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = UIDX_W + 1;

    fp_divsqrt_alloc_entry_t entry_q [NUM_UNITS];

    logic [PTR_W-1:0]              rr_ptr;
    logic [PTR_W-1:0]              rr_ptr_next;
    logic [NUM_REQ-1:0]            eligible;
    logic [NUM_REQ-1:0][PTR_W-1:0] lane_pos;
    logic [NUM_REQ-1:0][PTR_W:0]   lane_rank;
    logic [NUM_UNITS-1:0]          unit_free;
    logic [NUM_UNITS-1:0]          flush_hit;
    logic [CNT_W-1:0]              free_total;
    logic [CNT_W-1:0]              free_rank [NUM_UNITS];

    // A unit freed this cycle only becomes grantable next cycle: no bypass.
    always_comb begin
        unit_free  = '0;
        unit_owned = '0;
        free_total = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            unit_owned[u] = entry_q[u].owned;
            unit_free[u]  = ~entry_q[u].owned;
            free_rank[u]  = free_total;
            if (unit_free[u])
                free_total = free_total + CNT_W'(1);
        end
    end

    assign free_count = free_total;

    always_comb begin
        flush_hit = '0;
        eligible  = '0;
        for (int u = 0; u < NUM_UNITS; u++)
            flush_hit[u] = flush_valid && entry_q[u].owned &&
                           (flush_all || in_flush_range(entry_q[u].tag, flush_head, flush_tail));
        for (int i = 0; i < NUM_REQ; i++)
            eligible[i] = !rst && req_valid[i] &&
                          !(flush_valid && (flush_all ||
                            in_flush_range(req_tag[i*TAG_W +: TAG_W], flush_head, flush_tail)));
    end

    fp_divsqrt_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .rr_ptr (rr_ptr),
        .req    (eligible),
        .pos    (lane_pos),
        .rank   (lane_rank)
    );

    // The k-th eligible lane in scan order takes the k-th lowest free unit.
    always_comb begin
        grant        = '0;
        grant_unit   = '0;
        unit_acquire = '0;
        unit_tag     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (eligible[i] && (int'(lane_rank[i]) < int'(free_total))) begin
                grant[i] = 1'b1;
                for (int u = 0; u < NUM_UNITS; u++) begin
                    if (unit_free[u] && (int'(free_rank[u]) == int'(lane_rank[i]))) begin
                        grant_unit[i*UIDX_W +: UIDX_W] = UIDX_W'(u);
                        unit_acquire[u]                = 1'b1;
                        unit_tag[u*TAG_W +: TAG_W]     = req_tag[i*TAG_W +: TAG_W];
                    end
                end
            end
        end
    end

    always_comb begin
        int last_pos;
        last_pos    = -1;
        rr_ptr_next = rr_ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i] && (int'(lane_pos[i]) > last_pos)) begin
                last_pos    = int'(lane_pos[i]);
                rr_ptr_next = PTR_W'((i + 1) % NUM_REQ);
            end
        end
    end

    // NOTE: the entry array is a handful of flops, so it is reset like any
    // other state; it is not a RAM and must come up unowned.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            for (int u = 0; u < NUM_UNITS; u++)
                entry_q[u] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            rr_ptr <= rr_ptr_next;
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (unit_acquire[u]) begin
                    entry_q[u].owned <= 1'b1;
                    entry_q[u].tag   <= unit_tag[u*TAG_W +: TAG_W];
                end else if (unit_release[u] || flush_hit[u]) begin
                    entry_q[u].owned <= 1'b0;
                end
            end
        end
    end

`ifdef FP_DIVSQRT_ALLOC_STATS_EN
    logic [32:0] grants_sum;
    logic        any_stall;

    assign grants_sum = {1'b0, stat_grants} + 33'($countones(grant));
    assign any_stall  = |(req_valid & ~grant);

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grants <= '0;
            stat_stalls <= '0;
        end else begin
            stat_grants <= grants_sum[32] ? '1 : grants_sum[31:0];
            if (any_stall && (stat_stalls != '1))
                stat_stalls <= stat_stalls + 32'd1;
        end
    end
`endif

endmodule
